pwm_channel_scanner: RTL and testbench
======================================

// Module: pwm_channel_scanner
// PURPOSE
//  Round-robin scheduler sharing one pulse-width counter among NUM_CH RC servo-style inputs.
//  Measures one channel at a time, stores per-channel width and valid flag, detects dead/stuck
//  channels by timeout, and raises failsafe when no channel is valid. Sits between the
//  receiver pins and the stepper setpoint logic; widths are in clk_in cycles.
//  A full 2 ms pulse at 25 MHz reads as 50000.
// PARAMETERS
//  NUM_CH      4                 number of pulse inputs scanned (>=1)
//  SIZE        17                width of each stored pulse width, bits
//  SYSCLK      25000000          clk_in frequency, Hz
//  TIMEOUT_CYC SYSCLK/40         max cycles waiting for low+rise on a channel (25 ms)
//  MAX_WIDTH   (SYSCLK/1000)*3   max high time before channel declared stuck (3 ms)
//  CLAMP_LO    SYSCLK/1000       lower clamp bound (1 ms), used only with RANGE_CLAMP_EN
//  CLAMP_HI    SYSCLK/500        upper clamp bound (2 ms), used only with RANGE_CLAMP_EN
// PORTS
//  clk_in        in   1            system clock
//  reset_n_in    in   1            asynchronous active-low reset
//  pulse_in      in   NUM_CH       raw asynchronous pulse inputs, bit i = channel i
//  width_out     out  NUM_CH*SIZE  stored widths, channel i at [i*SIZE +: SIZE]
//  valid_out     out  NUM_CH       bit i = channel i holds a fresh, in-limit measurement
//  update_out    out  1            one-cycle strobe when a width is written
//  ch_out        out  $clog2(NUM_CH) (min 1)  channel currently scheduled; on update_out = channel written
//  failsafe_out  out  1            high when valid_out == 0
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-measurement): width_out=0, valid_out=0, update_out=0,
//    ch_out=0, failsafe_out=1, counter/timer=0, state=ARM, synchronisers cleared to 0.
//  - Each pulse_in bit passes a 2-FF synchroniser; all rules below use synced value s[ch].
//  - One SIZE-bit width counter and one timer ($clog2(TIMEOUT_CYC+1) bits) shared by all channels.
//  - FSM:
//    ARM:       timer++. s[ch]==0 -> WAIT_RISE (timer kept). Guarantees no mid-pulse capture.
//    WAIT_RISE: timer++. s[ch]==1 -> MEASURE, counter<=1 (rise cycle counts as 1).
//    MEASURE:   s[ch]==1 -> counter++. s[ch]==0 -> STORE.
//               counter==MAX_WIDTH while still high -> FAIL (stuck high).
//    STORE:     width_out[ch]<=counter (clamped if enabled), valid_out[ch]<=1, update_out=1 -> NEXT.
//    FAIL:      valid_out[ch]<=0, width_out[ch] unchanged, no strobe -> NEXT.
//    NEXT:      ch<=(ch==NUM_CH-1)?0:ch+1; counter<=0; timer<=0 -> ARM.
//    Timeout: in ARM or WAIT_RISE, timer==TIMEOUT_CYC-1 -> FAIL (timeout wins over same-cycle edge).
//  - Width rule: synced input high for N consecutive cycles stores N (1<=N<=MAX_WIDTH-1).
//  - Latency: update_out asserts 2 cycles after the first synced-low cycle of the pulse
//    (MEASURE->STORE, STORE registers); ch_out stays equal to written channel during strobe.
//  - Counter never wraps: MAX_WIDTH must be < 2**SIZE (elaboration $error otherwise).
//  - failsafe_out = ~|valid_out (combinational from registered valid_out).
//  - NUM_CH==1: ch_out constant 0, scheduling degenerates to repeated single-channel capture.
//  - Other channels' edges during another channel's slot are ignored; each slot costs at
//    least one frame, so a full scan takes ~NUM_CH frames.
// CONFIGURATION
//  RANGE_CLAMP_EN defined: stored width = min(max(counter,CLAMP_LO),CLAMP_HI); valid still set.
//  RANGE_CLAMP_EN undefined: stored width = raw counter; CLAMP_LO/CLAMP_HI unused.
// TESTING  (bench params: NUM_CH=3, SIZE=12, TIMEOUT_CYC=1000, MAX_WIDTH=500, CLAMP 100/300)
//  1. ch0 pulse high 250 cycles after 50 low -> update_out, ch_out=0, width[0]=250, valid=001, failsafe=0.
//  2. pulses 120/200/280 on ch0/1/2 each frame -> three strobes in order 0,1,2, then ch_out wraps to 0.
//  3. ch1 held low forever -> FAIL 1000 cycles after ARM entry, valid[1]=0, width[1] keeps old value.
//  4. ch2 held high 600 cycles -> FAIL at counter 500, no strobe, valid[2]=0; all invalid -> failsafe=1.
//  5. reset_n_in low at counter=130 on ch1 -> all outputs reset immediately, scan restarts at ch0 ARM.
//  6. RANGE_CLAMP_EN set: pulses 50 and 400 -> widths 100 and 300; unset -> 50 and 400.

Source files
------------

// File: rtl/pwm_channel_scanner.sv
// pwm_channel_scanner: round-robin pulse-width capture of NUM_CH servo inputs with one shared counter.
// Optional RANGE_CLAMP_EN clamps stored widths to [CLAMP_LO, CLAMP_HI].
`default_nettype none

module pwm_channel_scanner #(
  parameter int NUM_CH      = 4,
  parameter int SIZE        = 17,
  parameter int SYSCLK      = 25000000,
  parameter int TIMEOUT_CYC = SYSCLK / 40,
  parameter int MAX_WIDTH   = (SYSCLK / 1000) * 3,
  parameter int CLAMP_LO    = SYSCLK / 1000,
  parameter int CLAMP_HI    = SYSCLK / 500
) (
  input  logic                                         clk_in,
  input  logic                                         reset_n_in,
  input  logic [NUM_CH-1:0]                            pulse_in,
  output logic [NUM_CH*SIZE-1:0]                       width_out,
  output logic [NUM_CH-1:0]                            valid_out,
  output logic                                         update_out,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_out,
  output logic                                         failsafe_out
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  generate
    if (MAX_WIDTH >= (2 ** SIZE)) begin : g_chk_size
      $error("MAX_WIDTH must be below 2**SIZE so the width counter cannot wrap");
    end
    if (CLAMP_LO > CLAMP_HI) begin : g_chk_clamp
      $error("CLAMP_LO must not exceed CLAMP_HI");
    end
  endgenerate

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    WAIT_RISE = 3'd1,
    MEASURE   = 3'd2,
    STORE     = 3'd3,
    FAIL      = 3'd4,
    NEXT      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]            sync1, sync2;
  logic [CHW-1:0]               ch;
  logic [SIZE-1:0]              counter;
  logic [TW-1:0]                timer;
  logic [NUM_CH-1:0][SIZE-1:0]  widths;
  logic [NUM_CH-1:0]            valid;
  logic                         update;

  logic                         cur;
  logic                         timeout;
  logic                         at_max;
  logic [SIZE-1:0]              store_val;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    cur     = sync2[ch];
    timeout = (timer == TW'(TIMEOUT_CYC - 1));
    at_max  = (counter == SIZE'(MAX_WIDTH));
`ifdef RANGE_CLAMP_EN
    if (counter < SIZE'(CLAMP_LO)) begin
      store_val = SIZE'(CLAMP_LO);
    end else if (counter > SIZE'(CLAMP_HI)) begin
      store_val = SIZE'(CLAMP_HI);
    end else begin
      store_val = counter;
    end
`else
    store_val = counter;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Timeout takes priority over an edge seen in the same cycle.
      ARM: begin
        if (timeout)   state_d = FAIL;
        else if (!cur) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (timeout)  state_d = FAIL;
        else if (cur) state_d = MEASURE;
      end
      MEASURE: begin
        if (!cur)        state_d = STORE;
        else if (at_max) state_d = FAIL;
      end
      STORE:   state_d = NEXT;
      FAIL:    state_d = NEXT;
      NEXT:    state_d = ARM;
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ARM;
      ch      <= '0;
      counter <= '0;
      timer   <= '0;
      widths  <= '0;
      valid   <= '0;
      update  <= 1'b0;
    end else begin
      state_q <= state_d;
      update  <= 1'b0;
      case (state_q)
        ARM: begin
          timer <= timer + 1'b1;
        end
        WAIT_RISE: begin
          timer <= timer + 1'b1;
          // The rise cycle itself is the first high cycle of the pulse.
          if (!timeout && cur) counter <= SIZE'(1);
        end
        MEASURE: begin
          if (cur && !at_max) counter <= counter + 1'b1;
        end
        STORE: begin
          widths[ch] <= store_val;
          valid[ch]  <= 1'b1;
          update     <= 1'b1;
        end
        FAIL: begin
          valid[ch] <= 1'b0;
        end
        NEXT: begin
          ch      <= (ch == CHW'(NUM_CH - 1)) ? '0 : ch + 1'b1;
          counter <= '0;
          timer   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign width_out    = widths;
  assign valid_out    = valid;
  assign update_out   = update;
  assign ch_out       = ch;
  assign failsafe_out = ~|valid;

endmodule

`default_nettype wire

// File: tb/tb_pwm_channel_scanner.sv
// Scoreboard bench for pwm_channel_scanner: slot-level reference model, randomized pulse slots.
`default_nettype none

module tb_pwm_channel_scanner;

  localparam int NUM_CH      = 3;
  localparam int SIZE        = 12;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_WIDTH   = 500;
  localparam int CLAMP_LO    = 100;
  localparam int CLAMP_HI    = 300;
  localparam int CHW         = 2;

  logic                   clk_in = 1'b0;
  logic                   reset_n_in = 1'b0;
  logic [NUM_CH-1:0]      pulse_in = '0;
  logic [NUM_CH*SIZE-1:0] width_out;
  logic [NUM_CH-1:0]      valid_out;
  logic                   update_out;
  logic [CHW-1:0]         ch_out;
  logic                   failsafe_out;

  pwm_channel_scanner #(
    .NUM_CH(NUM_CH), .SIZE(SIZE), .SYSCLK(100000), .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_WIDTH(MAX_WIDTH), .CLAMP_LO(CLAMP_LO), .CLAMP_HI(CLAMP_HI)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .pulse_in(pulse_in),
    .width_out(width_out), .valid_out(valid_out), .update_out(update_out),
    .ch_out(ch_out), .failsafe_out(failsafe_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int                     ch;
    int                     at;
    logic [NUM_CH*SIZE-1:0] widths;
    logic [NUM_CH-1:0]      valid;
  } exp_t;
  exp_t sbq[$];

  int m_width[NUM_CH];
  bit m_valid[NUM_CH];
  int slot_ch = 0;
  bit tgt = 1'b0;
  bit noise = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CH*SIZE-1:0] model_widths();
    logic [NUM_CH*SIZE-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*SIZE +: SIZE] = SIZE'(m_width[c]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_valid();
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_valid[c];
    return v;
  endfunction

  function automatic int clampw(input int n);
`ifdef RANGE_CLAMP_EN
    if (n < CLAMP_LO) return CLAMP_LO;
    if (n > CLAMP_HI) return CLAMP_HI;
`endif
    return n;
  endfunction

  // Drive the scheduled channel from tgt; other channels carry noise or sit low.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      for (int c = 0; c < NUM_CH; c++)
        pulse_in[c] = (c == slot_ch) ? tgt : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  // kind 0: good pulse of n cycles, kind 1: over-long pulse (stuck), kind 2: no rise (timeout)
  task automatic run_slot(input int kind, input int low_len, input int n);
    int fall;
    exp_t e;
    tgt = 1'b0;
    noise = 1'b1;
    if (kind == 2) begin
      tick(900);
      noise = 1'b0;
      tick(250);
      m_valid[slot_ch] = 1'b0;
    end else begin
      tick(low_len);
      if (kind == 1) noise = 1'b0;
      tgt = 1'b1;
      tick(n);
      tgt = 1'b0;
      tick(1);
      fall = cyc;
      if (kind == 0) begin
        m_width[slot_ch] = clampw(n);
        m_valid[slot_ch] = 1'b1;
        e.ch = slot_ch;
        e.at = fall + 4;
        e.widths = model_widths();
        e.valid = model_valid();
        sbq.push_back(e);
      end else begin
        m_valid[slot_ch] = 1'b0;
      end
      noise = 1'b0;
      tick(10);
    end
    if (kind != 0) begin
      check("fail_valid", valid_out, model_valid());
      check("fail_width_kept", width_out, model_widths());
      check("fail_failsafe", failsafe_out, (model_valid() == '0));
    end
    slot_ch = (slot_ch + 1) % NUM_CH;
  endtask

  task automatic random_slot();
    int r = $urandom_range(0, 9);
    int n;
    if (r < 8) begin
      n = (r == 0) ? 1 : (r == 1) ? MAX_WIDTH - 1 : $urandom_range(1, MAX_WIDTH - 1);
      run_slot(0, $urandom_range(2, 50), n);
    end else if (r == 8) begin
      run_slot(1, $urandom_range(2, 50), $urandom_range(MAX_WIDTH + 1, MAX_WIDTH + 150));
    end else begin
      run_slot(2, 0, 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_width"}, width_out, '0);
    check({tag, "_valid"}, valid_out, '0);
    check({tag, "_update"}, update_out, 1'b0);
    check({tag, "_ch"}, ch_out, '0);
    check({tag, "_failsafe"}, failsafe_out, 1'b1);
  endtask

  always @(negedge clk_in) begin
    if (reset_n_in && update_out) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: ch_out=%0d with none expected (cycle %0d)", ch_out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("strobe_ch", ch_out, e.ch);
        check("strobe_cycle", cyc, e.at);
        check("strobe_widths", width_out, e.widths);
        check("strobe_valid", valid_out, e.valid);
        check("strobe_failsafe", failsafe_out, (e.valid == '0));
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation budget exceeded at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      m_width[c] = 0;
      m_valid[c] = 1'b0;
    end
    tick(3);
    check_reset_state("reset");
    reset_n_in = 1'b1;
    tick(2);

    run_slot(0, 50, 250);
    run_slot(0, 20, 200);
    run_slot(0, 20, 280);
    run_slot(0, 20, 120);
    run_slot(2, 0, 0);
    run_slot(1, 20, 600);
    run_slot(1, 20, MAX_WIDTH + 1);
    run_slot(0, 10, 50);
    run_slot(0, 10, 400);
    run_slot(0, 10, MAX_WIDTH - 1);
    run_slot(0, 10, 1);
    run_slot(0, 10, 300);

    repeat (30) random_slot();
    while (slot_ch != 1) random_slot();

    // Async reset in the middle of a channel-1 measurement.
    tgt = 1'b0;
    noise = 1'b1;
    tick(20);
    tgt = 1'b1;
    tick(130);
    reset_n_in = 1'b0;
    #1;
    check_reset_state("midreset");
    tgt = 1'b0;
    noise = 1'b0;
    sbq.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      m_width[c] = 0;
      m_valid[c] = 1'b0;
    end
    slot_ch = 0;
    tick(3);
    reset_n_in = 1'b1;
    tick(2);

    run_slot(0, 30, 222);
    repeat (6) random_slot();

    tick(20);
    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
